log_iter_unit: RTL and testbench

Parametrised, iterative natural-log unit for the AWGN generator's Box-Muller front end: it takes a uniform sample u in (0,1) and returns -ln(u) or -2·ln(u) in fixed point. It is the next generation of the fixed pipelined log block and adds these features:
- selectable width and precision;
- a per-sample scale mode;
- valid/ready handshakes on both sides;
- a bit-exact shift-and-square log2 engine in place of table lookup;
- a zero-input error flag.

It sits between the uniform RNG and the sqrt stage.

---
 rtl/log_iter_unit.sv | 160 ++++++++++++++++
 tb/tb_log_iter_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_iter_unit.sv
// rtl/log_iter_unit.sv - iterative -ln(u) / -2ln(u) unit using a shift-and-square log2 engine
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid, in_ready    input handshake for log_in (u, UQ0.W_IN) and mode
//   mode                  0: -ln(u), 1: -2ln(u)
//   out_valid, out_ready  output handshake for log_out and err
//   log_out               result, UQ(W_OUT-OUT_FRAC).OUT_FRAC, saturates to all ones
//   err                   input was zero (log_out is all ones)
module log_iter_unit #(
    parameter int          W_IN      = 48,
    parameter int          W_OUT     = 31,
    parameter int          OUT_FRAC  = 24,
    parameter int          FRAC_BITS = 16,
    parameter int          MANT_BITS = 30,
    parameter logic [31:0] LN2       = 32'hB17217F7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  log_in,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] log_out,
    output logic             err
);

    localparam int LZ_W  = $clog2(W_IN + 1);
    localparam int L_W   = LZ_W + FRAC_BITS;
    localparam int P_W   = L_W + 33;
    localparam int SHIFT = FRAC_BITS + 32 - OUT_FRAC;
    localparam int CNT_W = $clog2(FRAC_BITS + 1);
    localparam int EXT_W = W_IN + 1 + MANT_BITS;
    localparam int M_W   = MANT_BITS + 1;
    localparam int SQ_W  = 2 * M_W;

    typedef enum logic [2:0] {IDLE, NORM, ITER, MUL, DONE} state_t;

    state_t state, state_n;

    logic [W_IN-1:0]      u_reg;
    logic                 mode_reg;
    logic [LZ_W-1:0]      lz_reg;
    logic [M_W-1:0]       m_reg;
    logic [FRAC_BITS-1:0] f_reg;
    logic [CNT_W-1:0]     cnt;

    logic [LZ_W-1:0]  lz;
    logic [LZ_W:0]    lz_p1;
    logic [EXT_W-1:0] ext_sh;
    logic [M_W-1:0]   m_norm;
    logic [SQ_W-1:0]  sq;
    logic [M_W:0]     s;
    logic [M_W-1:0]   m_next;
    logic [L_W-1:0]   l_val;
    logic [P_W-1:0]   p_base;
    logic [P_W-1:0]   p_val;
    logic [P_W-1:0]   p_shift;
    logic             sat;
    logic [W_OUT-1:0] out_calc;

    // Leading-zero count: the highest set bit wins because it is visited last.
    always_comb begin
        lz = LZ_W'(W_IN);
        for (int i = 0; i < W_IN; i++) begin
            if (u_reg[i]) lz = LZ_W'(W_IN - 1 - i);
        end
    end

    // Normalise: the leading one lands on the top bit of the extended vector,
    // the MANT_BITS bits below it become the mantissa fraction.
    always_comb begin
        lz_p1  = {1'b0, lz} + (LZ_W + 1)'(1);
        ext_sh = {1'b0, u_reg, {MANT_BITS{1'b0}}} << lz_p1;
        m_norm = M_W'(ext_sh >> (EXT_W - M_W));
    end

    // One log2 bit per square: UQ1.M squared is UQ2.2M, truncated back to UQ2.M.
    always_comb begin
        sq     = SQ_W'(m_reg) * SQ_W'(m_reg);
        s      = (M_W + 1)'(sq >> MANT_BITS);
        m_next = s[M_W] ? s[M_W:1] : s[M_W-1:0];
    end

    // -log2(u) = (lz+1) - 0.f, then scaled by ln2 (and by 2 for mode 1).
    always_comb begin
        l_val    = ((L_W'(lz_reg) + L_W'(1)) << FRAC_BITS) - L_W'(f_reg);
        p_base   = P_W'(l_val) * P_W'(LN2);
        p_val    = mode_reg ? (p_base << 1) : p_base;
        p_shift  = p_val >> SHIFT;
        sat      = (p_shift >> W_OUT) != '0;
        out_calc = sat ? '1 : W_OUT'(p_shift);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (in_valid) state_n = NORM;
            NORM: state_n = (u_reg == '0) ? DONE : ITER;
            ITER: if (cnt == CNT_W'(FRAC_BITS - 1)) state_n = MUL;
            MUL:  state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            u_reg    <= '0;
            mode_reg <= 1'b0;
            lz_reg   <= '0;
            m_reg    <= '0;
            f_reg    <= '0;
            cnt      <= '0;
            log_out  <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        u_reg    <= log_in;
                        mode_reg <= mode;
                    end
                end
                NORM: begin
                    lz_reg <= lz;
                    m_reg  <= m_norm;
                    f_reg  <= '0;
                    cnt    <= '0;
                    if (u_reg == '0) begin
                        err     <= 1'b1;
                        log_out <= '1;
                    end else begin
                        err <= 1'b0;
                    end
                end
                ITER: begin
                    m_reg <= m_next;
                    f_reg <= {f_reg[FRAC_BITS-2:0], s[M_W]};
                    cnt   <= cnt + CNT_W'(1);
                end
                MUL: begin
                    log_out <= out_calc;
                    err     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_log_iter_unit.sv
// tb/tb_log_iter_unit.sv - self-checking bench for log_iter_unit
module tb_log_iter_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] log_in = '0;
    logic        mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [30:0] log_out;
    logic        err;

    int checks = 0;
    int errors = 0;

    log_iter_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .log_in    (log_in),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .log_out   (log_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic on the mathematical definition.
    function automatic void model(input logic [47:0] u, input logic md,
                                  output logic [30:0] o, output logic e);
        int msb, lz;
        longint unsigned m, s, f, l, p, r;
        if (u == 0) begin
            o = '1;
            e = 1'b1;
            return;
        end
        msb = 0;
        for (int i = 0; i < 48; i++) if (u[i]) msb = i;
        lz = 47 - msb;
        m = ((64'(u)) << (lz + 1)) >> 18;
        f = 0;
        for (int k = 0; k < 16; k++) begin
            s = (m * m) >> 30;
            if (s >= (64'd2 << 30)) begin
                f = f * 2 + 1;
                m = s >> 1;
            end else begin
                f = f * 2;
                m = s;
            end
        end
        l = 64'(lz + 1) * 65536 - f;
        p = l * 64'hB17217F7 * (md ? 64'd2 : 64'd1);
        r = p >> 24;
        o = (r > 64'h7FFFFFFF) ? 31'h7FFFFFFF : r[30:0];
        e = 1'b0;
    endfunction

    function automatic logic [47:0] rand_u();
        logic [63:0] t;
        t = {$urandom, $urandom};
        if ($urandom_range(0, 49) == 0) return 48'h0;
        return t[47:0] >> $urandom_range(0, 47);
    endfunction

    // Drives one sample through with out_ready low until out_valid, then releases.
    // lat counts cycles from the accept cycle to the first cycle with out_valid.
    task automatic run_one(input logic [47:0] u, input logic md,
                           output logic [30:0] o, output logic e, output int lat);
        int guard;
        @(negedge clk);
        in_valid  = 1'b1;
        log_in    = u;
        mode      = md;
        out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
            log_in   = rand_u();
            mode     = ~md;
        end while (!out_valid && lat < 200);
        if (!out_valid) lat = -1;
        o = log_out;
        e = err;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (log_out !== 31'h0) begin errors++; $display("FAIL reset_log_out got %h want 0", log_out); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    endtask

    task automatic test_known();
        logic [47:0] us   [6] = '{48'h800000000000, 48'h800000000000, 48'h400000000000,
                                  48'h000000000001, 48'h000000000001, 48'hFFFFFFFFFFFF};
        logic        ms   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [30:0] exps [6] = '{31'h00B17217, 31'h0162E42F, 31'h0162E42F,
                                  31'h2145647E, 31'h428AC8FC, 31'h000000B1};
        logic [30:0] o;
        logic        e;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_one(us[i], ms[i], o, e, lat);
            checks++;
            if (o !== exps[i]) begin errors++; $display("FAIL known_%0d_log_out got %h want %h", i, o, exps[i]); end
            checks++;
            if (e !== 1'b0) begin errors++; $display("FAIL known_%0d_err got %b want 0", i, e); end
            checks++;
            if (lat != 19) begin errors++; $display("FAIL known_%0d_latency got %0d want 19", i, lat); end
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0)
                begin errors++; $display("FAIL known_%0d_release got in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid); end
        end
    endtask

    task automatic test_zero();
        logic [30:0] o;
        logic        e;
        int          lat;
        run_one(48'h0, 1'b1, o, e, lat);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL zero_err got %b want 1", e); end
        checks++;
        if (o !== 31'h7FFFFFFF) begin errors++; $display("FAIL zero_log_out got %h want 7fffffff", o); end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL zero_latency got %0d want 2", lat); end
        run_one(48'h800000000000, 1'b0, o, e, lat);
        checks++;
        if (e !== 1'b0 || o !== 31'h00B17217)
            begin errors++; $display("FAIL after_zero got err=%b log_out=%h want 0/00b17217", e, o); end
    endtask

    task automatic test_backpressure();
        logic [30:0] held, o, exp_o;
        logic        e, exp_e;
        int          guard, lat;
        @(negedge clk);
        in_valid = 1'b1; log_in = 48'h123456789ABC; mode = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 100) begin @(negedge clk); guard++; end
        checks++;
        if (!out_valid) begin errors++; $display("FAIL bp_timeout got out_valid=0 want 1"); end
        model(48'h123456789ABC, 1'b1, exp_o, exp_e);
        held = log_out;
        checks++;
        if (held !== exp_o) begin errors++; $display("FAIL bp_value got %h want %h", held, exp_o); end
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            log_in = rand_u();
            @(negedge clk);
            checks++;
            if (log_out !== held || out_valid !== 1'b1 || in_ready !== 1'b0)
                begin errors++; $display("FAIL bp_hold_%0d got log_out=%h ov=%b ir=%b want %h/1/0", i, log_out, out_valid, in_ready, held); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL bp_release got ir=%b ov=%b want 1/0", in_ready, out_valid); end
        run_one(48'h000F00000000, 1'b0, o, e, lat);
        model(48'h000F00000000, 1'b0, exp_o, exp_e);
        checks++;
        if (o !== exp_o || e !== exp_e)
            begin errors++; $display("FAIL bp_next got %h/%b want %h/%b", o, e, exp_o, exp_e); end
    endtask

    task automatic test_random();
        logic [30:0] q_o[$];
        logic        q_e[$];
        logic [30:0] mo, prev_out;
        logic        me, prev_hold;
        int          accepted, cycles;
        accepted  = 0;
        cycles    = 0;
        prev_hold = 1'b0;
        prev_out  = '0;
        while ((accepted < 1000 || q_o.size() != 0 || out_valid) && cycles < 60000) begin
            @(negedge clk);
            cycles++;
            if (in_ready && out_valid) begin
                checks++; errors++;
                $display("FAIL rand_exclusive got in_ready=1 out_valid=1 want not both");
            end
            if (prev_hold) begin
                checks++;
                if (log_out !== prev_out || out_valid !== 1'b1)
                    begin errors++; $display("FAIL rand_hold got %h/%b want %h/1", log_out, out_valid, prev_out); end
            end
            in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            log_in    = rand_u();
            mode      = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) begin
                model(log_in, mode, mo, me);
                q_o.push_back(mo);
                q_e.push_back(me);
                accepted++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q_o.size() == 0) begin
                    errors++; $display("FAIL rand_extra got output %h want none", log_out);
                end else begin
                    mo = q_o.pop_front();
                    me = q_e.pop_front();
                    if (log_out !== mo || err !== me)
                        begin errors++; $display("FAIL rand_result got %h/%b want %h/%b", log_out, err, mo, me); end
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = log_out;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (cycles >= 60000) begin errors++; $display("FAIL rand_timeout got %0d accepted want 1000 drained", accepted); end
    endtask

    task automatic test_reset_mid();
        logic [30:0] o, exp_o;
        logic        e, exp_e;
        int          lat;
        @(negedge clk);
        in_valid = 1'b1; log_in = 48'h9ABCDEF01234; mode = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || log_out !== 31'h0)
            begin errors++; $display("FAIL mid_reset got ir=%b ov=%b log_out=%h want 1/0/0", in_ready, out_valid, log_out); end
        run_one(48'h0000ABCDEF12, 1'b1, o, e, lat);
        model(48'h0000ABCDEF12, 1'b1, exp_o, exp_e);
        checks++;
        if (o !== exp_o || e !== exp_e || lat != 19)
            begin errors++; $display("FAIL mid_after got %h/%b lat %0d want %h/%b lat 19", o, e, lat, exp_o, exp_e); end
    endtask

    initial begin
        test_reset();
        test_known();
        test_zero();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
